// File: rtl/traffic_timer_pkg.sv
// Shared constants and phase naming for the traffic timer, FSM and bench.
// Also holds the write-validation rule used by the duration table.
package traffic_timer_pkg;

   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned DEF_DUR   = 30;

   // Phase order for the standard four-phase intersection.
   typedef enum logic [1:0] {
      PH_NS_GREEN  = 2'd0,
      PH_NS_YELLOW = 2'd1,
      PH_EW_GREEN  = 2'd2,
      PH_EW_YELLOW = 2'd3
   } phase_e;

   // A zero duration would never terminate a phase, so it is refused.
   function automatic logic dur_write_ok(input int unsigned addr,
                                         input int unsigned dur,
                                         input int unsigned n_phases);
      return (dur != 0) && (addr < n_phases);
   endfunction

endpackage

// File: rtl/phase_dur_regfile.sv
// Per-phase duration table with validated writes, error pulse, and a read
// port that forwards a same-cycle write to the addressed entry.
module phase_dur_regfile
   import traffic_timer_pkg::*;
#(
   parameter int unsigned N_PHASES    = 4,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned DEFAULT_DUR = DEF_DUR,
   parameter int unsigned PH_W        = $clog2(N_PHASES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [PH_W-1:0]  addr,
   input  logic [CNT_W-1:0] wdata,
   input  logic [PH_W-1:0]  rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic             err
);

   logic [CNT_W-1:0] dur_q [N_PHASES];
   logic             wr_ok;
   logic             wr_en;

   always_comb begin
      wr_ok = dur_write_ok(int'(addr), int'(wdata), N_PHASES);
      wr_en = we && wr_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_PHASES; i++) begin
            dur_q[i] <= CNT_W'(DEFAULT_DUR);
         end
         err <= 1'b0;
      end else begin
         err <= we && !wr_ok;
         if (wr_en) begin
            dur_q[addr] <= wdata;
         end
      end
   end

   // Forwarding lets a write landing on the advance edge take effect at once.
   always_comb begin
      if (wr_en && (addr == rd_addr)) begin
         rd_data = wdata;
      end else begin
         rd_data = dur_q[rd_addr];
      end
   end

endmodule

// File: rtl/multi_phase_timer.sv
// Sequences N_PHASES phases with programmable durations; emits the phase
// index, ticks remaining, a phase-change pulse and a config error pulse.
module multi_phase_timer
   import traffic_timer_pkg::*;
#(
   parameter int unsigned N_PHASES    = 4,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned DEFAULT_DUR = DEF_DUR,
   parameter int unsigned PH_W        = $clog2(N_PHASES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             tick,
   input  logic             skip,
   input  logic             cfg_we,
   input  logic [PH_W-1:0]  cfg_addr,
   input  logic [CNT_W-1:0] cfg_dur,
   output logic [PH_W-1:0]  phase,
   output logic [CNT_W-1:0] remaining,
   output logic             signal_change,
   output logic             cfg_err
);

   logic [PH_W-1:0]  next_idx;
   logic [CNT_W-1:0] next_dur;
   logic             advance;
   logic [PH_W-1:0]  phase_d;
   logic [CNT_W-1:0] remaining_d;
   logic             change_d;

   phase_dur_regfile #(
      .N_PHASES    (N_PHASES),
      .CNT_W       (CNT_W),
      .DEFAULT_DUR (DEFAULT_DUR),
      .PH_W        (PH_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (cfg_we),
      .addr    (cfg_addr),
      .wdata   (cfg_dur),
      .rd_addr (next_idx),
      .rd_data (next_dur),
      .err     (cfg_err)
   );

   always_comb begin
      // Explicit wrap so non-power-of-two phase counts never overrun.
      next_idx    = (phase == PH_W'(N_PHASES - 1)) ? '0 : phase + 1'b1;
      advance     = en && ((tick && (remaining == '0)) || skip);
      phase_d     = phase;
      remaining_d = remaining;
      change_d    = 1'b0;
      if (advance) begin
         phase_d     = next_idx;
         remaining_d = next_dur - 1'b1;
         change_d    = 1'b1;
      end else if (en && tick) begin
         remaining_d = remaining - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase         <= '0;
         remaining     <= CNT_W'(DEFAULT_DUR - 1);
         signal_change <= 1'b0;
      end else begin
         phase         <= phase_d;
         remaining     <= remaining_d;
         signal_change <= change_d;
      end
   end

endmodule

// File: tb/tb_multi_phase_timer.sv
// Directed bench for multi_phase_timer: a 4-phase and a 3-phase instance
// share stimulus; a behavioural model feeds an expectation queue.
module tb_multi_phase_timer;
   import traffic_timer_pkg::*;

   logic       clk = 1'b0;
   logic       rst, en, tick, skip, cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_dur;
   logic [1:0] phase, phase3;
   logic [7:0] remaining, remaining3;
   logic       signal_change, signal_change3, cfg_err, cfg_err3;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      int inst;
      int ph;
      int rem;
      int sc;
      int err;
   } exp_t;

   exp_t sbq[$];

   int m_ph  [2];
   int m_rem [2];
   int m_sc  [2];
   int m_err [2];
   int m_tbl [2][4];
   int m_n   [2] = '{4, 3};

   multi_phase_timer dut (
      .clk(clk), .rst(rst), .en(en), .tick(tick), .skip(skip),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dur(cfg_dur),
      .phase(phase), .remaining(remaining),
      .signal_change(signal_change), .cfg_err(cfg_err)
   );

   multi_phase_timer #(.N_PHASES(3)) dut3 (
      .clk(clk), .rst(rst), .en(en), .tick(tick), .skip(skip),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dur(cfg_dur),
      .phase(phase3), .remaining(remaining3),
      .signal_change(signal_change3), .cfg_err(cfg_err3)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_and_push();
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         int   nph;
         int   nd;
         bit   ok;
         bit   adv;
         if (rst) begin
            m_ph[k]  = 0;
            m_rem[k] = DEF_DUR - 1;
            m_sc[k]  = 0;
            m_err[k] = 0;
            for (int i = 0; i < 4; i++) m_tbl[k][i] = DEF_DUR;
         end else begin
            ok  = cfg_we && (cfg_dur != 0) && (int'(cfg_addr) < m_n[k]);
            nph = (m_ph[k] == m_n[k] - 1) ? 0 : m_ph[k] + 1;
            adv = en && ((tick && m_rem[k] == 0) || skip);
            m_err[k] = (cfg_we && !ok) ? 1 : 0;
            if (adv) begin
               nd = (ok && int'(cfg_addr) == nph) ? int'(cfg_dur) : m_tbl[k][nph];
               m_ph[k]  = nph;
               m_rem[k] = nd - 1;
               m_sc[k]  = 1;
            end else begin
               m_sc[k] = 0;
               if (en && tick) m_rem[k] = m_rem[k] - 1;
            end
            if (ok) m_tbl[k][cfg_addr] = cfg_dur;
         end
         e.inst = k; e.ph = m_ph[k]; e.rem = m_rem[k]; e.sc = m_sc[k]; e.err = m_err[k];
         sbq.push_back(e);
      end
   endtask

   task automatic step();
      exp_t e;
      model_and_push();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = sbq.pop_front();
         if (e.inst == 0) begin
            chk("n4_phase", 32'(phase), e.ph);
            chk("n4_remaining", 32'(remaining), e.rem);
            chk("n4_signal_change", 32'(signal_change), e.sc);
            chk("n4_cfg_err", 32'(cfg_err), e.err);
         end else begin
            chk("n3_phase", 32'(phase3), e.ph);
            chk("n3_remaining", 32'(remaining3), e.rem);
            chk("n3_signal_change", 32'(signal_change3), e.sc);
            chk("n3_cfg_err", 32'(cfg_err3), e.err);
         end
      end
   endtask

   task automatic run_until(input int target);
      int c = 0;
      while (!(int'(phase) == target && signal_change) && c < 400) begin
         step();
         c++;
      end
      chk("run_until_entry", 32'(int'(phase) == target && signal_change), 1);
   endtask

   task automatic measure(input int period, input int freeze_at, output int len);
      len = 0;
      do begin
         tick = ((len % period) == period - 1);
         en   = !(len >= freeze_at && len < freeze_at + 10);
         skip = !en;
         step();
         len++;
      end while (!signal_change && len < 300);
      tick = 1'b1;
      en   = 1'b1;
      skip = 1'b0;
   endtask

   task automatic wait_rem_zero();
      int c = 0;
      while (remaining != 8'd0 && c < 300) begin
         step();
         c++;
      end
      chk("wait_rem_zero", 32'(remaining), 0);
   endtask

   initial begin
      int len;
      rst = 1'b1; en = 1'b1; tick = 1'b1; skip = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_dur = '0;
      step();
      step();
      chk("reset_phase", 32'(phase), 0);
      chk("reset_remaining", 32'(remaining), 29);
      chk("reset_change", 32'(signal_change), 0);

      // Default run: 30 ticks per phase, wrap after 120 edges (90 for N=3).
      rst = 1'b0;
      repeat (29) step();
      chk("p0_last_tick_rem", 32'(remaining), 0);
      chk("p0_last_tick_phase", 32'(phase), 0);
      step();
      chk("edge30_phase", 32'(phase), 1);
      chk("edge30_change", 32'(signal_change), 1);
      chk("edge30_remaining", 32'(remaining), 29);
      step();
      chk("pulse_width", 32'(signal_change), 0);
      repeat (59) step();
      chk("n3_wrap_phase", 32'(phase3), 0);
      chk("n3_wrap_change", 32'(signal_change3), 1);
      chk("edge90_phase", 32'(phase), 3);
      repeat (30) step();
      chk("edge120_wrap_phase", 32'(phase), 0);
      chk("edge120_wrap_change", 32'(signal_change), 1);

      // Rejected writes: zero duration, and an address past the last phase.
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_dur = 8'd0;
      step();
      chk("zero_dur_err", 32'(cfg_err), 1);
      cfg_addr = 2'd3; cfg_dur = 8'd30;
      step();
      chk("n3_addr3_err", 32'(cfg_err3), 1);
      chk("n4_addr3_ok", 32'(cfg_err), 0);
      cfg_we = 1'b0;
      step();
      chk("n3_err_clears", 32'(cfg_err3), 0);
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_dur = 8'd5;
      step();
      cfg_we = 1'b0;
      run_until(int'(PH_NS_YELLOW));
      measure(1, 1_000_000, len);
      chk("p1_len_after_zero_write", len, 30);
      measure(1, 1_000_000, len);
      chk("p2_len_dur5", len, 5);

      // Write on the advance edge into the phase being entered.
      run_until(int'(PH_NS_GREEN));
      wait_rem_zero();
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_dur = 8'd3;
      step();
      cfg_we = 1'b0;
      chk("fwd_phase", 32'(phase), 1);
      chk("fwd_remaining", 32'(remaining), 2);
      measure(1, 1_000_000, len);
      chk("p1_len_fwd3", len, 3);

      // Tick every 4th cycle with duration 2.
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_dur = 8'd2;
      step();
      cfg_we = 1'b0;
      run_until(int'(PH_EW_GREEN));
      measure(4, 1_000_000, len);
      chk("gated_tick_len", len, 8);

      // Freeze for 10 cycles mid-phase with skip held (ignored).
      measure(1, 5, len);
      chk("freeze_len", len, 40);

      // Skip mid-phase, then skip coinciding with the terminal tick.
      repeat (12) step();
      chk("pre_skip_rem", 32'(remaining), 17);
      skip = 1'b1;
      step();
      skip = 1'b0;
      chk("skip_phase", 32'(phase), 1);
      chk("skip_change", 32'(signal_change), 1);
      chk("skip_remaining", 32'(remaining), 2);
      wait_rem_zero();
      skip = 1'b1;
      step();
      skip = 1'b0;
      chk("skip_tick_phase", 32'(phase), 2);
      chk("skip_tick_remaining", 32'(remaining), 1);
      step();
      chk("skip_tick_single", 32'(phase), 2);

      // Mid-phase reset restores the default table.
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_dur = 8'd9;
      step();
      cfg_addr = 2'd2; cfg_dur = 8'd20;
      step();
      cfg_we = 1'b0;
      run_until(int'(PH_EW_GREEN));
      repeat (12) step();
      chk("pre_rst_remaining", 32'(remaining), 7);
      rst = 1'b1; skip = 1'b1;
      step();
      rst = 1'b0; skip = 1'b0;
      chk("rst_phase", 32'(phase), 0);
      chk("rst_remaining", 32'(remaining), 29);
      measure(1, 1_000_000, len);
      chk("rst_p0_len", len, 30);
      measure(1, 1_000_000, len);
      chk("rst_p1_len", len, 30);
      measure(1, 1_000_000, len);
      chk("rst_p2_len", len, 30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_phase_timer.md
Name: multi_phase_timer

Overview:
Parametrised successor of the traffic controller's single-interval change timer. Sequences N_PHASES light phases, each with its own runtime-programmable duration, and emits the current phase index, the remaining count and a one-cycle signal_change pulse on every phase advance. Sits between the traffic FSM (which decodes phase into lamp outputs) and a config/host interface. Adds tick gating, enable/freeze, a forced-advance request and config error flagging.

Parameters:
N_PHASES, 4, number of phases in the cycle (>=2)
CNT_W, 8, duration/counter width in ticks
DEFAULT_DUR, 30, reset duration of every phase, in ticks (1..2^CNT_W-1)
PH_W, $clog2(N_PHASES), phase index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en  in  1  run enable; low freezes phase/counter
tick  in  1  count strobe; tie high for per-cycle counting
skip  in  1  force advance to next phase
cfg_we  in  1  duration table write strobe
cfg_addr  in  PH_W  phase whose duration is written
cfg_dur  in  CNT_W  new duration in ticks
phase  out  PH_W  current phase index
remaining  out  CNT_W  ticks left in current phase, minus one
signal_change  out  1  one-cycle pulse, coincident with phase update
cfg_err  out  1  one-cycle pulse on rejected write

Behaviour:
- Reset (rst high at clk edge): phase=0, remaining=DEFAULT_DUR-1, signal_change=0, cfg_err=0, all table entries=DEFAULT_DUR. Reset mid-phase aborts it; same values regardless of en/tick/skip.
- Phase lasts dur[phase] ticks: remaining counts dur-1 down to 0.
- Advance condition (en=1): (tick=1 and remaining==0) or skip=1. skip and a terminal tick in one cycle -> single advance.
- On advance edge: phase <= (phase==N_PHASES-1) ? 0 : phase+1; remaining <= dur[next]-1; signal_change <= 1 for exactly that cycle. Non-power-of-2 N_PHASES must wrap at N_PHASES-1.
- en=1, tick=1, remaining>0, skip=0: remaining decrements by 1; signal_change=0.
- en=1, tick=0, skip=0: hold.
- en=0: phase, remaining hold; skip ignored; signal_change=0. Config writes still accepted.
- Config write: if cfg_dur!=0 and cfg_addr<N_PHASES, dur[cfg_addr] <= cfg_dur next edge; else table unchanged and cfg_err=1 next cycle.
- Written value never alters remaining of the current phase; applies on next entry to that phase.
- Write to dur[next] in the same cycle as an advance: new value forwarded, remaining <= cfg_dur-1.
- All outputs registered; no combinational path input->output.

Decomposition:
- Package traffic_timer_pkg: DEFAULT_DUR default, CNT_W default, phase enum for N=4 (PH_NS_GREEN=0, PH_NS_YELLOW=1, PH_EW_GREEN=2, PH_EW_YELLOW=3), shared by traffic FSM and bench.
- Sub-module phase_dur_regfile: N_PHASES x CNT_W table with reset-to-default, validated write, cfg_err generation, and write-forwarding read port for the next-phase index. Top holds counter, phase register, advance logic.

Test Plan:
- Defaults, tick=1, en=1: release rst -> remaining 29..0, phase=1 with signal_change=1 on 30th edge after release; phase wraps 3->0 on 120th; pulse width exactly 1 cycle.
- Write dur[2]=5 while phase=0 -> phase 2 lasts 5 cycles; write dur[1]=3 on the advance-to-1 edge -> phase 1 lasts 3 (forwarding).
- Write cfg_dur=0 to phase 1 -> cfg_err=1 one cycle, phase 1 still 30 ticks; N_PHASES=3 build, cfg_addr=3 -> cfg_err, wrap 2->0.
- tick every 4th cycle, dur=2 -> phase lasts 8 cycles; en low for 10 cycles mid-phase -> remaining frozen, skip ignored, phase extended by 10.
- skip at remaining=17 -> next edge phase+1, remaining=dur-1, one pulse; skip with remaining==0 and tick -> single advance, not two.
- rst for one cycle at phase=2, remaining=7 after dur[0]=9 written -> phase=0, remaining=29, table back to 30.
